// File: rtl/counter_pkg.sv
// Shared constants and helpers for updown_mod_counter and its prescaler.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int PRESCALE_WIDTH = 16;

  // Operands are 33 bits so that MODULUS-1 of a 32-bit counter still fits.
  function automatic logic [32:0] clamp_load(input logic [32:0] val,
                                             input logic [32:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: counts en-high cycles 0..PRESCALE-1 and ticks on the last one.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRESCALE_WIDTH-1:0] LAST = PRESCALE_WIDTH'(PRESCALE - 1);

  logic [PRESCALE_WIDTH-1:0] phase;

  assign tick = en && (phase == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with clamped load, tc pulse and sticky ovf.
// Optional enable divider selected by the UPDOWN_COUNTER_PRESCALE_EN macro.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // One extra bit keeps MODULUS-1 exact even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MAX_VAL = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP     = MAX_VAL[WIDTH-1:0];

  logic             tick;
  logic             step;
  logic             step_wrap;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH:0]   count_ext;

  assign count_ext    = {1'b0, count};
  assign load_clamped = WIDTH'(clamp_load(33'(load_val), 33'(MAX_VAL)));
  assign step         = en && tick;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (en),
    .tick (tick)
  );
`else
  // No divider in this build: any legal PRESCALE makes tick a constant 1.
  assign tick = (PRESCALE != 0) && (PRESCALE < (1 << PRESCALE_WIDTH));
`endif

  always_comb begin
    step_val  = count;
    step_wrap = 1'b0;
    case (up)
      DIR_UP: begin
        if (count_ext == MAX_VAL) begin
          step_val  = '0;
          step_wrap = 1'b1;
        end else begin
          step_val = WIDTH'(count_ext + (WIDTH + 1)'(1));
        end
      end
      DIR_DOWN: begin
        if (count == '0) begin
          step_val  = TOP;
          step_wrap = 1'b1;
        end else begin
          step_val = count - WIDTH'(1);
        end
      end
    endcase
  end

  // A wrap sets ovf in the same edge, so it beats a simultaneous ovf_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
      ovf   <= ovf && !ovf_clr;
    end else if (step) begin
      count <= step_val;
      tc    <= step_wrap;
      ovf   <= step_wrap || (ovf && !ovf_clr);
    end else begin
      tc    <= 1'b0;
      ovf   <= ovf && !ovf_clr;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: MODULUS=10 main instance, a
// MODULUS=2**WIDTH=2 instance, and a PRESCALE=3 instance when the macro is set.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       en = 1'b0, up = 1'b1, load = 1'b0, ovf_clr = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count;
  logic       tc, ovf;

  logic       en2 = 1'b0, up2 = 1'b1, load2 = 1'b0, ovf_clr2 = 1'b0;
  logic [0:0] load_val2 = 1'b0;
  logic [0:0] count2;
  logic       tc2, ovf2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(count), .tc(tc), .ovf(ovf)
  );

  updown_mod_counter #(.WIDTH(1), .MODULUS(2), .PRESCALE(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .up(up2), .load(load2), .load_val(load_val2),
    .ovf_clr(ovf_clr2), .count(count2), .tc(tc2), .ovf(ovf2)
  );

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  logic       en3 = 1'b0, up3 = 1'b1, load3 = 1'b0, ovf_clr3 = 1'b0;
  logic [3:0] load_val3 = 4'd0;
  logic [3:0] count3;
  logic       tc3, ovf3;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .up(up3), .load(load3), .load_val(load_val3),
    .ovf_clr(ovf_clr3), .count(count3), .tc(tc3), .ovf(ovf3)
  );
`endif

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick_clk();
    checks++;
    if ({count, tc, ovf} !== 6'b0000_0_0)
      $display("[TB] FAIL reset: count=%0d tc=%0b ovf=%0b, expected 0/0/0", count, tc, ovf);
    else passed++;
    checks++;
    if ({count2, tc2, ovf2} !== 3'b000)
      $display("[TB] FAIL reset_mod2: count=%0d tc=%0b ovf=%0b, expected 0/0/0", count2, tc2, ovf2);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_c;
    logic       exp_tc, exp_ovf;
    en = 1'b1;
    up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick_clk();
      exp_c   = 4'(k % 10);
      exp_tc  = (k == 10);
      exp_ovf = (k >= 10);
      checks++;
      if (count !== exp_c || tc !== exp_tc || ovf !== exp_ovf)
        $display("[TB] FAIL up_wrap step %0d: count=%0d tc=%0b ovf=%0b, expected %0d/%0b/%0b",
                 k, count, tc, ovf, exp_c, exp_tc, exp_ovf);
      else passed++;
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_c [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    load_val = 4'd2;
    load = 1'b1;
    tick_clk();
    load = 1'b0;
    checks++;
    if (count !== 4'd2 || tc !== 1'b0 || ovf !== 1'b1)
      $display("[TB] FAIL down_load: count=%0d tc=%0b ovf=%0b, expected 2/0/1", count, tc, ovf);
    else passed++;
    up = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick_clk();
      checks++;
      if (count !== exp_c[k] || tc !== (exp_c[k] == 4'd9))
        $display("[TB] FAIL down_wrap step %0d: count=%0d tc=%0b, expected %0d/%0b",
                 k, count, tc, exp_c[k], exp_c[k] == 4'd9);
      else passed++;
    end
    en = 1'b0;
    up = 1'b1;
  endtask

  task automatic test_load_clamp();
    load_val = 4'd13;
    load = 1'b1;
    en = 1'b1;
    up = 1'b1;
    tick_clk();
    load = 1'b0;
    checks++;
    if (count !== 4'd9 || tc !== 1'b0)
      $display("[TB] FAIL load_clamp: count=%0d tc=%0b, expected 9/0", count, tc);
    else passed++;
    tick_clk();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1)
      $display("[TB] FAIL load_clamp_step: count=%0d tc=%0b ovf=%0b, expected 0/1/1", count, tc, ovf);
    else passed++;
    en = 1'b0;
  endtask

  task automatic test_dir_change();
    logic       dirs  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_c [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up = dirs[k];
      tick_clk();
      checks++;
      if (count !== exp_c[k] || tc !== 1'b0)
        $display("[TB] FAIL dir_change step %0d: count=%0d tc=%0b, expected %0d/0", k, count, tc, exp_c[k]);
      else passed++;
    end
    en = 1'b0;
    up = 1'b1;
    tick_clk();
    checks++;
    if (count !== 4'd2 || tc !== 1'b0)
      $display("[TB] FAIL hold: count=%0d tc=%0b, expected 2/0", count, tc);
    else passed++;
  endtask

  task automatic test_ovf_clr_race();
    load_val = 4'd9;
    load = 1'b1;
    tick_clk();
    load = 1'b0;
    en = 1'b1;
    up = 1'b1;
    ovf_clr = 1'b1;
    tick_clk();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1)
      $display("[TB] FAIL ovf_clr_race: count=%0d tc=%0b ovf=%0b, expected 0/1/1", count, tc, ovf);
    else passed++;
    en = 1'b0;
    tick_clk();
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0)
      $display("[TB] FAIL ovf_clr: count=%0d tc=%0b ovf=%0b, expected 0/0/0", count, tc, ovf);
    else passed++;
    ovf_clr = 1'b0;
    tick_clk();
    checks++;
    if (ovf !== 1'b0)
      $display("[TB] FAIL ovf_stays_clear: ovf=%0b, expected 0", ovf);
    else passed++;
  endtask

  task automatic test_reset_mid();
    load_val = 4'd9;
    load = 1'b1;
    tick_clk();
    load = 1'b0;
    en = 1'b1;
    tick_clk();
    en = 1'b0;
    load_val = 4'd7;
    load = 1'b1;
    tick_clk();
    checks++;
    if (count !== 4'd7 || ovf !== 1'b1)
      $display("[TB] FAIL load_keeps_ovf: count=%0d ovf=%0b, expected 7/1", count, ovf);
    else passed++;
    rst = 1'b1;
    en = 1'b1;
    load_val = 4'd5;
    tick_clk();
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0)
      $display("[TB] FAIL reset_mid: count=%0d tc=%0b ovf=%0b, expected 0/0/0", count, tc, ovf);
    else passed++;
    rst = 1'b0;
    load = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_mod2();
    logic [0:0] exp_c;
    en2 = 1'b1;
    up2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick_clk();
      exp_c = 1'(k % 2);
      checks++;
      if (count2 !== exp_c || tc2 !== (exp_c == 1'b0) || ovf2 !== (k >= 2))
        $display("[TB] FAIL mod2_up step %0d: count=%0d tc=%0b ovf=%0b, expected %0d/%0b/%0b",
                 k, count2, tc2, ovf2, exp_c, exp_c == 1'b0, k >= 2);
      else passed++;
    end
    up2 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick_clk();
      exp_c = 1'(k % 2);
      checks++;
      if (count2 !== exp_c || tc2 !== (exp_c == 1'b1))
        $display("[TB] FAIL mod2_down step %0d: count=%0d tc=%0b, expected %0d/%0b",
                 k, count2, tc2, exp_c, exp_c == 1'b1);
      else passed++;
    end
    en2 = 1'b0;
  endtask

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    logic       ens   [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    logic [3:0] exp_c [11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    logic [3:0] exp_l [4]  = '{5, 5, 5, 6};
    for (int k = 0; k < 11; k++) begin
      en3 = ens[k];
      tick_clk();
      checks++;
      if (count3 !== exp_c[k] || tc3 !== 1'b0)
        $display("[TB] FAIL prescale step %0d: count=%0d tc=%0b, expected %0d/0", k, count3, tc3, exp_c[k]);
      else passed++;
    end
    en3 = 1'b1;
    load_val3 = 4'd5;
    for (int k = 0; k < 4; k++) begin
      load3 = (k == 0);
      tick_clk();
      checks++;
      if (count3 !== exp_l[k])
        $display("[TB] FAIL prescale_load step %0d: count=%0d, expected %0d", k, count3, exp_l[k]);
      else passed++;
    end
    load3 = 1'b0;
    en3 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_dir_change();
    test_ovf_clr_race();
    test_reset_mid();
    test_mod2();
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
